// File: rtl/actor_motion_engine.sv
// Sequential per-tick movement engine for N_ACTORS sprites sharing one collision-map port.
// Optional macro ACTOR_MOTION_ENGINE_OVERRUN_CNT_EN adds o_overrun_cnt (dropped tick edges).
module actor_motion_engine #(
    parameter int N_ACTORS   = 4,
    parameter int STEP       = 4,
    parameter int TILE_SHIFT = 4,
    parameter int SCREEN_W   = 800,
    parameter int SCREEN_H   = 600,
    parameter int START_X    = 64,
    parameter int START_Y    = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_tick,
    input  logic [4*N_ACTORS-1:0]   i_dir_req,
    output logic [5:0]              o_map_x,
    output logic [4:0]              o_map_y,
    output logic                    o_map_rd,
    input  logic                    i_map_tile,
    output logic [10*N_ACTORS-1:0]  o_pos_x,
    output logic [10*N_ACTORS-1:0]  o_pos_y,
    output logic [3*N_ACTORS-1:0]   o_dir,
    output logic                    o_busy,
    output logic                    o_done
`ifdef ACTOR_MOTION_ENGINE_OVERRUN_CNT_EN
    ,
    output logic [7:0]              o_overrun_cnt
`endif
);

    localparam int IDX_W = (N_ACTORS > 1) ? $clog2(N_ACTORS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ACTORS - 1);
    localparam int T = 1 << TILE_SHIFT;

    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] W_MAX  = 11'(SCREEN_W - 1);
    localparam logic [10:0] H_MAX  = 11'(SCREEN_H - 1);
    localparam logic [10:0] TILE   = 11'(T);
    localparam logic [10:0] HALF   = 11'(T / 2);
    localparam logic [10:0] TLOW   = 11'(T - 1);

    localparam logic [2:0] DIR_RIGHT = 3'b000;
    localparam logic [2:0] DIR_DOWN  = 3'b001;
    localparam logic [2:0] DIR_LEFT  = 3'b010;
    localparam logic [2:0] DIR_UP    = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_MOVE, S_SNAP, S_PROBE, S_WAIT, S_COMMIT, S_DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              tick_q;
    logic              tick_edge;
    logic [3:0]        req;
    logic [9:0]        cand_x, cand_y;
    logic [2:0]        cand_dir;
    logic              moving;
    logic              wall;

    logic [9:0]        cur_x, cur_y;
    logic [2:0]        cur_dir;
    logic [10:0]       x11, y11;
    logic [9:0]        mv_x, mv_y;
    logic [2:0]        mv_dir;
    logic [9:0]        sn_x, sn_y;
    logic [10:0]       px, py;

    function automatic logic [9:0] snap(input logic [9:0] c);
        logic [10:0] base;
        base = {1'b0, c} & ~TLOW;
        if (({1'b0, c} & TLOW) >= HALF)
            base = base + TILE;
        return base[9:0];
    endfunction

    assign tick_edge = i_tick & ~tick_q;
    assign cur_x     = o_pos_x[10*idx +: 10];
    assign cur_y     = o_pos_y[10*idx +: 10];
    assign cur_dir   = o_dir[3*idx +: 3];
    assign x11       = {1'b0, cur_x};
    assign y11       = {1'b0, cur_y};

    // Candidate move: up > right > down > left, wrapping at the screen edges.
    always_comb begin
        mv_x   = cur_x;
        mv_y   = cur_y;
        mv_dir = cur_dir;
        if (req[3]) begin
            mv_y   = (y11 < STEP_W) ? H_MAX[9:0] : 10'(y11 - STEP_W);
            mv_dir = DIR_UP;
        end else if (req[2]) begin
            mv_x   = (x11 + STEP_W > W_MAX) ? 10'd0 : 10'(x11 + STEP_W);
            mv_dir = DIR_RIGHT;
        end else if (req[1]) begin
            mv_y   = (y11 + STEP_W > H_MAX) ? 10'd0 : 10'(y11 + STEP_W);
            mv_dir = DIR_DOWN;
        end else if (req[0]) begin
            mv_x   = (x11 < STEP_W) ? W_MAX[9:0] : 10'(x11 - STEP_W);
            mv_dir = DIR_LEFT;
        end
    end

    // Bit 0 of the facing code is the vertical flag; a turn snaps the cross-axis coordinate.
    always_comb begin
        sn_x = cand_x;
        sn_y = cand_y;
        if (cand_dir[0] != cur_dir[0]) begin
            if (cand_dir[0])
                sn_x = snap(cand_x);
            else
                sn_y = snap(cand_y);
        end
        case (cand_dir)
            DIR_UP: begin
                px = {1'b0, sn_x} + HALF;
                py = {1'b0, sn_y};
            end
            DIR_RIGHT: begin
                px = {1'b0, sn_x} + TILE;
                py = {1'b0, sn_y} + HALF;
            end
            DIR_DOWN: begin
                px = {1'b0, sn_x} + HALF;
                py = {1'b0, sn_y} + TILE;
            end
            default: begin
                px = {1'b0, sn_x};
                py = {1'b0, sn_y} + HALF;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            tick_q   <= 1'b0;
            req      <= '0;
            cand_x   <= '0;
            cand_y   <= '0;
            cand_dir <= '0;
            moving   <= 1'b0;
            wall     <= 1'b0;
            o_map_x  <= '0;
            o_map_y  <= '0;
            o_map_rd <= 1'b0;
            o_pos_x  <= {N_ACTORS{10'(START_X)}};
            o_pos_y  <= {N_ACTORS{10'(START_Y)}};
            o_dir    <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            tick_q <= i_tick;
            case (state)
                S_IDLE: begin
                    if (tick_edge) begin
                        idx    <= '0;
                        o_busy <= 1'b1;
                        state  <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    req   <= i_dir_req[4*idx +: 4];
                    state <= S_MOVE;
                end
                // The idle-actor decision is made here on the latched request, giving LATCH/MOVE/COMMIT.
                S_MOVE: begin
                    cand_x   <= mv_x;
                    cand_y   <= mv_y;
                    cand_dir <= mv_dir;
                    moving   <= |req;
                    state    <= (|req) ? S_SNAP : S_COMMIT;
                end
                S_SNAP: begin
                    cand_x   <= sn_x;
                    cand_y   <= sn_y;
                    o_map_x  <= 6'(px >> TILE_SHIFT);
                    o_map_y  <= 5'(py >> TILE_SHIFT);
                    o_map_rd <= 1'b1;
                    state    <= S_PROBE;
                end
                S_PROBE: begin
                    o_map_rd <= 1'b0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wall  <= i_map_tile;
                    state <= S_COMMIT;
                end
                S_COMMIT: begin
                    if (moving) begin
                        o_dir[3*idx +: 3] <= cand_dir;
                        if (!wall) begin
                            o_pos_x[10*idx +: 10] <= cand_x;
                            o_pos_y[10*idx +: 10] <= cand_y;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        o_done <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_LATCH;
                    end
                end
                S_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ACTOR_MOTION_ENGINE_OVERRUN_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_overrun_cnt <= '0;
        else if (tick_edge && state != S_IDLE && o_overrun_cnt != 8'hFF)
            o_overrun_cnt <= o_overrun_cnt + 8'd1;
    end
`else
    // Tick edges arriving mid-pass are dropped without any record.
`endif

endmodule

// File: tb/tb_actor_motion_engine.sv
// Scoreboard bench for actor_motion_engine: a behavioural model predicts probes and pass results.
module tb_actor_motion_engine;

    localparam int N  = 4;
    localparam int ST = 4;
    localparam int T  = 16;
    localparam int W  = 800;
    localparam int H  = 600;
    localparam int SX = 64;
    localparam int SY = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tick = 1'b0;
    logic [4*N-1:0]    dir_req = '0;
    logic [5:0]        map_x;
    logic [4:0]        map_y;
    logic              map_rd;
    logic              map_tile = 1'b0;
    logic [10*N-1:0]   pos_x, pos_y;
    logic [3*N-1:0]    dir;
    logic              busy, done;
`ifdef ACTOR_MOTION_ENGINE_OVERRUN_CNT_EN
    logic [7:0]        overrun_cnt;
`endif

    always #5 clk = ~clk;

    actor_motion_engine #(
        .N_ACTORS(N), .STEP(ST), .TILE_SHIFT(4), .SCREEN_W(W), .SCREEN_H(H),
        .START_X(SX), .START_Y(SY)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_dir_req(dir_req),
        .o_map_x(map_x), .o_map_y(map_y), .o_map_rd(map_rd), .i_map_tile(map_tile),
        .o_pos_x(pos_x), .o_pos_y(pos_y), .o_dir(dir), .o_busy(busy), .o_done(done)
`ifdef ACTOR_MOTION_ENGINE_OVERRUN_CNT_EN
        , .o_overrun_cnt(overrun_cnt)
`endif
    );

    typedef struct {
        logic [10*N-1:0] px;
        logic [10*N-1:0] py;
        logic [3*N-1:0]  dr;
        int              len;
    } exp_t;

    exp_t        sq[$];
    logic [10:0] pq[$];
    bit          walls [64][32];
    int          mx[N], my[N], md[N];
    int          tests = 0, fails = 0, dones = 0, probes_seen = 0, busy_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mx[k] = SX; my[k] = SY; md[k] = 0;
        end
    endtask

    function automatic int round_tile(input int c);
        return ((c + T / 2) / T * T) % 1024;
    endfunction

    function automatic bit is_vert(input int d);
        return (d == 1) || (d == 5);
    endfunction

    // Facing codes: 0 right, 1 down, 2 left, 5 up.
    task automatic model_actor(input int k, input logic [3:0] r, inout int len);
        int x, y, nd, px, py, tx, ty;
        if (r == 4'b0000) begin
            len += 3;
            return;
        end
        len += 6;
        x = mx[k];
        y = my[k];
        if (r[3]) begin
            y  = (y < ST) ? H - 1 : y - ST;
            nd = 5;
        end else if (r[2]) begin
            x  = (x + ST > W - 1) ? 0 : x + ST;
            nd = 0;
        end else if (r[1]) begin
            y  = (y + ST > H - 1) ? 0 : y + ST;
            nd = 1;
        end else begin
            x  = (x < ST) ? W - 1 : x - ST;
            nd = 2;
        end
        if (is_vert(nd) != is_vert(md[k])) begin
            if (is_vert(nd)) x = round_tile(x);
            else             y = round_tile(y);
        end
        case (nd)
            5:       begin px = x + T / 2; py = y;         end
            0:       begin px = x + T;     py = y + T / 2; end
            1:       begin px = x + T / 2; py = y + T;     end
            default: begin px = x;         py = y + T / 2; end
        endcase
        tx = (px / T) % 64;
        ty = (py / T) % 32;
        pq.push_back({6'(tx), 5'(ty)});
        md[k] = nd;
        if (!walls[tx][ty]) begin
            mx[k] = x;
            my[k] = y;
        end
    endtask

    task automatic predict(input logic [4*N-1:0] req);
        exp_t e;
        int   len;
        len = 0;
        for (int k = 0; k < N; k++) model_actor(k, req[4*k +: 4], len);
        e.len = len + 1;
        for (int k = 0; k < N; k++) begin
            e.px[10*k +: 10] = 10'(mx[k]);
            e.py[10*k +: 10] = 10'(my[k]);
            e.dr[3*k +: 3]   = 3'(md[k]);
        end
        sq.push_back(e);
    endtask

    task automatic clear_walls();
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 32; j++) walls[i][j] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pq.delete();
        sq.delete();
        model_reset();
        chk("reset_pos_x", pos_x, {N{10'(SX)}});
        chk("reset_pos_y", pos_y, {N{10'(SY)}});
        chk("reset_dir", dir, '0);
        chk("reset_busy_done_rd", {busy, done, map_rd}, 3'b000);
`ifdef ACTOR_MOTION_ENGINE_OVERRUN_CNT_EN
        chk("reset_overrun", overrun_cnt, 8'd0);
`endif
    endtask

    task automatic run_pass(input logic [4*N-1:0] req, input int hold, input bit second_edge);
        int d0, t;
        d0 = dones;
        dir_req = req;
        predict(req);
        @(posedge clk);
        #1 tick = 1'b1;
        repeat (hold) @(posedge clk);
        #1 tick = 1'b0;
        if (second_edge) begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
        t = 0;
        while (dones == d0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (dones == d0) begin
            tests++;
            fails++;
            $display("FAIL pass_timeout: got no done expected done within 400 cycles");
            pq.delete();
            sq.delete();
        end
        repeat (3) @(posedge clk);
        #1;
        if (second_edge) begin
            repeat (40) @(posedge clk);
            #1;
            chk("single_done", 64'(dones), 64'(d0 + 1));
`ifdef ACTOR_MOTION_ENGINE_OVERRUN_CNT_EN
            chk("overrun_cnt", overrun_cnt, 8'd1);
`endif
        end
    endtask

    // Collision map: answers a strobe one cycle later, drives noise otherwise.
    initial begin : map_model
        logic       rd;
        logic [5:0] ax;
        logic [4:0] ay;
        forever begin
            @(negedge clk);
            rd = map_rd;
            ax = map_x;
            ay = map_y;
            @(posedge clk);
            #1 map_tile = rd ? walls[ax][ay] : 1'($urandom_range(0, 1));
        end
    end

    initial begin : monitor
        exp_t e;
        logic [10:0] p;
        forever begin
            @(negedge clk);
            busy_cnt = busy ? busy_cnt + 1 : 0;
            if (map_rd) begin
                probes_seen++;
                if (pq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL probe_unexpected: got probe %0h expected none", {map_x, map_y});
                end else begin
                    p = pq.pop_front();
                    chk("probe_tile", {53'd0, map_x, map_y}, {53'd0, p});
                end
            end
            if (done) begin
                dones++;
                if (sq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done_unexpected: got done expected none");
                end else begin
                    e = sq.pop_front();
                    chk("pass_pos_x", pos_x, e.px);
                    chk("pass_pos_y", pos_y, e.py);
                    chk("pass_dir", dir, e.dr);
                    chk("pass_len", 64'(busy_cnt), 64'(e.len));
                end
            end
        end
    end

    initial begin : stimulus
        logic [4*N-1:0] req;
        int t, p0;
        clear_walls();
        do_reset();

        // Single mover on an empty map, then a turn that snaps x down.
        run_pass(16'h0004, 1, 1'b0);
        run_pass(16'h0002, 2, 1'b0);

        // Turn from x=72 snaps up to 80.
        do_reset();
        run_pass(16'h0004, 1, 1'b0);
        run_pass(16'h0004, 1, 1'b0);
        run_pass(16'h0002, 3, 1'b0);

        // Wall ahead at tile (5,4): blocked but faces the wall.
        do_reset();
        walls[5][4] = 1'b1;
        run_pass(16'h0004, 1, 1'b0);
        run_pass(16'h0001, 1, 1'b0);
        clear_walls();

        // Second edge mid-pass is dropped.
        do_reset();
        run_pass(16'h0104, 1, 1'b1);

        // Reset during actor2's WAIT aborts the pass.
        do_reset();
        p0 = probes_seen;
        dir_req = 16'h4444;
        predict(16'h4444);
        @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        t = 0;
        while (probes_seen < p0 + 3 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("probes_before_abort", 64'(probes_seen), 64'(p0 + 3));
        @(posedge clk);
        #1 do_reset();
        run_pass(16'h4444, 1, 1'b0);

        // Long straight runs cover all four screen wraps.
        do_reset();
        for (int i = 0; i < 140; i++) run_pass(16'h2814, 1, 1'b0);
        for (int i = 0; i < 50; i++)  run_pass(16'h0004, 1, 1'b0);

        // Random requests over random sparse maps.
        for (int i = 0; i < 60; i++) begin
            if (i % 10 == 0)
                for (int a = 0; a < 64; a++)
                    for (int b = 0; b < 32; b++) walls[a][b] = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < N; k++)
                req[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            run_pass(req, $urandom_range(1, 3), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/actor_motion_engine.md
Name: actor_motion_engine

Overview:
- Parametrised successor to the single-player movement FSM. Advances N_ACTORS sprites (player plus ghosts) once per game tick.
- Actors are processed sequentially through one shared collision-map read port.
- Per actor: movement, screen wrap, grid snapping, and a tile-collision check.
- Sits between the input/AI layer and the sprite renderer. Outputs hold stable between ticks.

Parameters:
- N_ACTORS, 4, number of actors processed per tick (1..8).
- STEP, 4, pixels moved per tick.
- TILE_SHIFT, 4, log2 of tile size in pixels (T = 1<<TILE_SHIFT).
- SCREEN_W, 800, visible width in pixels.
- SCREEN_H, 600, visible height in pixels.
- START_X, 64, reset x for all actors.
- START_Y, 64, reset y for all actors.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_tick  in  1  frame tick; only its rising edge starts a pass.
- i_dir_req  in  4*N_ACTORS  per-actor request {up,right,down,left}; actor k uses bits [4k+3:4k].
- o_map_x  out  6  tile column for collision lookup.
- o_map_y  out  5  tile row for collision lookup.
- o_map_rd  out  1  lookup strobe; tile is valid on i_map_tile exactly one cycle later.
- i_map_tile  in  1  1 = wall.
- o_pos_x  out  10*N_ACTORS  committed x per actor.
- o_pos_y  out  10*N_ACTORS  committed y per actor.
- o_dir  out  3*N_ACTORS  committed facing: right=000, down=001, left=010, up=101.
- o_busy  out  1  high from LATCH through DONE.
- o_done  out  1  one-cycle pulse when a pass completes.

Behaviour:
- Reset (clock edge with i_rst=1):
  - all o_pos = (START_X, START_Y); all o_dir = 000.
  - FSM to IDLE; actor index = 0; tick edge register cleared.
  - o_map_rd = 0, o_busy = 0, o_done = 0.
  - Reset mid-pass aborts the pass with no partial commit of the current actor.
- Tick edge detect: a registered copy of i_tick. A pass starts when i_tick=1 and the previous sample = 0, and only if the FSM is in IDLE. A rising edge while busy is dropped.
- FSM sequence: IDLE -> LATCH -> MOVE -> SNAP -> PROBE -> WAIT -> COMMIT -> (next actor: LATCH | last actor: DONE) -> IDLE.
- LATCH: capture the actor's 4 request bits. Priority is up > right > down > left. If all bits are 0, go straight to COMMIT with no position or direction change (3 cycles for an idle actor).
- MOVE: compute candidate (nx, ny) and candidate direction.
  - right: nx = x+STEP, or 0 if x+STEP > SCREEN_W-1.
  - left: nx = x-STEP, or SCREEN_W-1 if x < STEP.
  - down: ny = y+STEP, or 0 if y+STEP > SCREEN_H-1.
  - up: ny = y-STEP, or SCREEN_H-1 if y < STEP.
  - All arithmetic is 11-bit internally; results are truncated to 10 bits.
- SNAP: applies only when the candidate axis differs from the current o_dir axis (horizontal vs vertical).
  - The cross-axis coordinate rounds to the nearest multiple of T: low TILE_SHIFT bits >= T/2 round up, otherwise down.
  - A same-axis move or reversal does not snap.
- PROBE: drive o_map_rd=1 for one cycle with probe point p = (px, py), then o_map_x = px>>TILE_SHIFT, o_map_y = py>>TILE_SHIFT (truncated to 6 and 5 bits).
  - up: (nx+T/2, ny).
  - right: (nx+T, ny+T/2).
  - down: (nx+T/2, ny+T).
  - left: (nx, ny+T/2).
- WAIT: sample i_map_tile.
- COMMIT:
  - If the tile is 0, write the candidate position.
  - If the tile is 1, keep the old position.
  - The direction always updates for a moving actor, so a blocked actor still turns to face the wall.
  - Other actors' outputs are never touched.
- Pass latency: 6 cycles per moving actor, 3 per idle actor, plus 1 (DONE).
- DONE: o_done=1 for one cycle, then IDLE.
- Outputs change only in COMMIT. i_dir_req may change freely; it is only sampled in LATCH.

Optional Feature:
- Macro: ACTOR_MOTION_ENGINE_OVERRUN_CNT_EN.
- Defined: adds output o_overrun_cnt (8 bits).
  - Increments, saturating at 255, on each tick rising edge dropped because the FSM was not in IDLE.
  - Cleared by reset.
- Undefined: the port and its logic are absent; dropped ticks are silent.

Test Plan:
- Reset, then tick with actor0 = right, empty map -> after o_done: actor0 = (68,64), dir 000; actors 1..3 = (64,64), dir 000; pass length 6+3*3+1 = 16 cycles.
- Wall at tile (5,4); actor0 at (64,64) requests right -> probe o_map_x=5, o_map_y=4; position stays (64,64), dir = 000.
- Actor0 at (798,64) right -> (0,64). Actor0 at (2,64) left -> (799,64). Actor0 at (64,2) up -> (64,599).
- Actor0 at (70,64), dir 000, requests down, empty map -> x snaps to 64, probe (4,5), result (64,68), dir 001. Repeat from (72,64) -> x snaps to 80.
- Second i_tick edge 5 cycles into a pass -> ignored, exactly one o_done; with the macro defined, o_overrun_cnt = 1.
- Assert i_rst during WAIT of actor2 -> all actors return to (64,64), dir 000, o_busy=0; the next tick runs a clean full pass.
